// File: rtl/comp_seq.sv
// Chunk-serial magnitude comparator: compares WIDTH-bit operands CHUNK bits per
// cycle, MSB chunk first, exits at the first differing chunk; EQ/GT cascade and signed mode.
module comp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  input  logic             EQ1,
  input  logic             GT1,
  output logic             busy,
  output logic             done,
  output logic             EQ0,
  output logic             GT0,
  output logic             LT0
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CMP  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_sgn, r_eq1, r_gt1;
  logic [IW-1:0]    r_idx;
  logic             r_done, r_eq, r_gt, r_lt;

  logic [CHUNK-1:0] w_msk, w_ac, w_bc;
  logic             w_top, w_diff, w_last, w_gt;

  // Operands shift left each step, so the chunk under test is always the top one.
  always_comb begin
    w_top          = (r_idx == IW'(NCHUNK - 1));
    w_msk          = '0;
    w_msk[CHUNK-1] = w_top & r_sgn;
    w_ac           = r_a[WIDTH-1 -: CHUNK] ^ w_msk;
    w_bc           = r_b[WIDTH-1 -: CHUNK] ^ w_msk;
    w_diff         = (w_ac != w_bc);
    w_gt           = (w_ac > w_bc);
    w_last         = (r_idx == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_eq1   <= 1'b0;
      r_gt1   <= 1'b0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_sgn   <= is_signed;
            r_eq1   <= EQ1;
            r_gt1   <= GT1;
            r_idx   <= IW'(NCHUNK - 1);
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          if (w_diff) begin
            r_eq    <= 1'b0;
            r_gt    <= w_gt;
            r_lt    <= ~w_gt;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_last) begin
            // All chunks equal: outcome comes from the cascade inputs.
            r_eq    <= r_eq1;
            r_gt    <= r_gt1 & ~r_eq1;
            r_lt    <= ~r_eq1 & ~r_gt1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx - 1'b1;
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_CMP);
  assign done = r_done;
  assign EQ0  = r_eq;
  assign GT0  = r_gt;
  assign LT0  = r_lt;
endmodule

// File: tb/tb_comp_seq.sv
// Directed + sweep bench for comp_seq; three builds (CHUNK 8/32/4) share stimulus,
// the CHUNK=8 build is scored through an expected-result queue.
module tb_comp_seq;
  logic        clock, reset_n, start, is_signed, EQ1, GT1;
  logic [31:0] A, B;
  logic [2:0]  busy_v, done_v, eq_v, gt_v, lt_v;

  typedef struct { logic [2:0] res; int lat; } exp_t;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   CH[3] = '{8, 32, 4};

  comp_seq #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clock(clock), .reset_n(reset_n), .start(start), .A(A), .B(B),
    .is_signed(is_signed), .EQ1(EQ1), .GT1(GT1), .busy(busy_v[0]), .done(done_v[0]),
    .EQ0(eq_v[0]), .GT0(gt_v[0]), .LT0(lt_v[0]));
  comp_seq #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clock(clock), .reset_n(reset_n), .start(start), .A(A), .B(B),
    .is_signed(is_signed), .EQ1(EQ1), .GT1(GT1), .busy(busy_v[1]), .done(done_v[1]),
    .EQ0(eq_v[1]), .GT0(gt_v[1]), .LT0(lt_v[1]));
  comp_seq #(.WIDTH(32), .CHUNK(4)) u_c4 (
    .clock(clock), .reset_n(reset_n), .start(start), .A(A), .B(B),
    .is_signed(is_signed), .EQ1(EQ1), .GT1(GT1), .busy(busy_v[2]), .done(done_v[2]),
    .EQ0(eq_v[2]), .GT0(gt_v[2]), .LT0(lt_v[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: result from a full compare, latency from the first differing bit.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input logic e, input logic g, input int ch,
                                output logic [2:0] r, output int k);
    logic [31:0] x;
    int p;
    x = a ^ b;
    if (x == 0) begin
      k = 32 / ch;
      r = {e, g & ~e, ~e & ~g};
    end else begin
      p = 0;
      for (int i = 0; i < 32; i++) if (x[i]) p = i;
      k = (31 - p) / ch + 1;
      if (s ? ($signed(a) > $signed(b)) : (a > b)) r = 3'b010;
      else r = 3'b001;
    end
  endfunction

  task automatic check_done(input int d, input int cyc, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic e, input logic g);
    logic [2:0] r;
    int k;
    exp_t x;
    chk("onehot", $countones({eq_v[d], gt_v[d], lt_v[d]}), 1);
    if (d == 0) begin
      if (exp_q.size() == 0) chk("sb_empty", 0, 1);
      else begin
        x = exp_q.pop_front();
        chk("res_c8", {eq_v[0], gt_v[0], lt_v[0]}, x.res);
        chk("lat_c8", cyc, x.lat);
      end
    end else begin
      model(a, b, s, e, g, CH[d], r, k);
      chk($sformatf("res_c%0d", CH[d]), {eq_v[d], gt_v[d], lt_v[d]}, r);
      chk($sformatf("lat_c%0d", CH[d]), cyc, k);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic e, input logic g, input bit disturb);
    logic [2:0] r;
    int k;
    bit seen[3];
    seen = '{0, 0, 0};
    model(a, b, s, e, g, 8, r, k);
    exp_q.push_back('{res: r, lat: k});
    @(negedge clock);
    A = a; B = b; is_signed = s; EQ1 = e; GT1 = g; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = disturb;
    if (disturb) begin
      A = ~a; B = a; is_signed = ~s; EQ1 = ~e; GT1 = ~g;
    end
    chk("busy_rise", busy_v[0], 1);
    chk("done_early", done_v[0], 0);
    for (int cyc = 1; cyc <= 20 && !(seen[0] && seen[1] && seen[2]); cyc++) begin
      @(posedge clock);
      @(negedge clock);
      if (cyc == 1) start = 1'b0;
      for (int d = 0; d < 3; d++)
        if (!seen[d] && done_v[d]) begin
          seen[d] = 1;
          chk("busy_fall", busy_v[d], 0);
          check_done(d, cyc, a, b, s, e, g);
        end
    end
    for (int d = 0; d < 3; d++) if (!seen[d]) chk($sformatf("timeout_c%0d", CH[d]), 0, 1);
  endtask

  task automatic wait_done0(output int cyc);
    cyc = 0;
    while (!done_v[0] && cyc < 20) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end
    if (!done_v[0]) chk("timeout_b2b", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_v != 3'b000 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (busy_v != 3'b000) chk("timeout_idle", busy_v, 0);
    @(negedge clock);
  endtask

  initial begin
    logic [2:0] r;
    logic [31:0] a, b;
    int k, cyc;
    exp_t x;
    reset_n = 1'b0; start = 1'b0; A = '0; B = '0; is_signed = 0; EQ1 = 0; GT1 = 0;
    #12;
    chk("rst_out", {busy_v, done_v, eq_v, gt_v, lt_v}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run(32'h12345678, 32'h12345678, 0, 1, 0, 0);
    run(32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0);
    run(32'h80000000, 32'h7FFFFFFF, 1, 0, 0, 0);
    run(32'h000000FF, 32'h000000FE, 0, 0, 0, 0);
    run(32'h55555555, 32'h55555555, 0, 0, 0, 0);
    run(32'h55555555, 32'h55555555, 0, 0, 1, 0);
    run(32'h55555555, 32'h55555555, 0, 1, 0, 0);
    run(32'h55555555, 32'h55555555, 1, 1, 1, 0);

    // start held while busy with different operands must be ignored
    run(32'h00FF0000, 32'h00FE0000, 1, 0, 0, 1);
    run(32'hFFFFFFF0, 32'h00000010, 1, 1, 0, 1);

    // back-to-back: new start in the done cycle
    model(32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 8, r, k);
    exp_q.push_back('{res: r, lat: k});
    model(32'h12345678, 32'h12345678, 0, 1, 0, 8, r, k);
    exp_q.push_back('{res: r, lat: k});
    @(negedge clock);
    A = 32'h80000000; B = 32'h7FFFFFFF; is_signed = 0; EQ1 = 0; GT1 = 0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    wait_done0(cyc);
    A = 32'h12345678; B = 32'h12345678; EQ1 = 1; GT1 = 0; start = 1'b1;
    x = exp_q.pop_front();
    chk("b2b1_res", {eq_v[0], gt_v[0], lt_v[0]}, x.res);
    chk("b2b1_lat", cyc, x.lat);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("b2b_pulse", done_v[0], 0);
    chk("b2b_busy", busy_v[0], 1);
    wait_done0(cyc);
    x = exp_q.pop_front();
    chk("b2b2_res", {eq_v[0], gt_v[0], lt_v[0]}, x.res);
    chk("b2b2_lat", cyc, x.lat);
    wait_idle();

    // asynchronous reset in the middle of a compare
    @(negedge clock);
    A = 32'hAAAAAAAA; B = 32'hAAAAAAAA; EQ1 = 0; GT1 = 1; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid", {busy_v, done_v, eq_v, gt_v, lt_v}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run(32'h0000ABCD, 32'h0000ABCE, 0, 0, 0, 0);

    a = 32'h0;
    for (int i = 0; i < 8; i++) begin
      a += 32'h33333333;
      for (int j = 0; j < 3; j++) begin
        b = (j == 0) ? a : (j == 1) ? a + 32'd1 : a - 32'd1;
        for (int s = 0; s < 2; s++)
          run(a, b, s[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
    end

    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
